// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND command/address sequencer.
package nand_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd1,
        StAddr,
        StCmd2,
        StTwb,
        StWaitRb,
        StDone
    } nand_state_e;

    localparam int unsigned NAND_MAX_ADDR = 5;

    localparam logic [7:0] READ1 = 8'h00;
    localparam logic [7:0] READ2 = 8'h30;
    localparam logic [7:0] PROG1 = 8'h80;
    localparam logic [7:0] PROG2 = 8'h10;
    localparam logic [7:0] RESET = 8'hFF;

    function automatic logic [2:0] clamp_addr_cnt(input logic [2:0] n);
        return (n > 3'(NAND_MAX_ADDR)) ? 3'(NAND_MAX_ADDR) : n;
    endfunction

    function automatic logic [7:0] addr_byte(input logic [39:0] a, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = a[7:0];
            3'd1:    b = a[15:8];
            3'd2:    b = a[23:16];
            3'd3:    b = a[31:24];
            3'd4:    b = a[39:32];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nand_we_timer.sv
// One WE# byte cycle: low for TWP_CYC, high for TWH_CYC, byte_done on the last high cycle.
// A go on the byte_done cycle chains the next byte with no gap.
module nand_we_timer #(
    parameter int unsigned TWP_CYC = 2,
    parameter int unsigned TWH_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic we_n,
    output logic byte_done
);

    localparam int unsigned MaxCyc = (TWP_CYC > TWH_CYC) ? TWP_CYC : TWH_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    logic            active_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            we_n     <= 1'b1;
            cnt_q    <= '0;
        end else if (go) begin
            active_q <= 1'b1;
            we_n     <= 1'b0;
            cnt_q    <= '0;
        end else if (active_q) begin
            if (!we_n) begin
                if (cnt_q == CntW'(TWP_CYC - 1)) begin
                    we_n  <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end else if (cnt_q == CntW'(TWH_CYC - 1)) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign byte_done = active_q && we_n && (cnt_q == CntW'(TWH_CYC - 1));

endmodule

// File: rtl/nand_cmd_seq.sv
// NAND command/address sequencer: CMD1, 0-5 address bytes, optional CMD2, optional R/B# wait.
// Define NAND_RB_TIMEOUT_EN to bound the R/B# wait by TIMEOUT_CYC and report it on timeout.
module nand_cmd_seq #(
    parameter int unsigned TWP_CYC     = 2,
    parameter int unsigned TWH_CYC     = 2,
    parameter int unsigned TWB_CYC     = 3,
    parameter int unsigned TIMEOUT_CYC = 24000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd1,
    input  logic [39:0] addr,
    input  logic [2:0]  addr_cnt,
    input  logic        cmd2_en,
    input  logic [7:0]  cmd2,
    input  logic        wait_rb,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        nand_ce_n,
    output logic        nand_cle,
    output logic        nand_ale,
    output logic        nand_we_n,
    output logic [7:0]  nand_io_out,
    output logic        nand_io_oe,
    input  logic        nand_rb_n
);
    import nand_pkg::*;

    localparam int unsigned TwbW = (TWB_CYC > 1) ? $clog2(TWB_CYC) : 1;

    if (TWP_CYC < 1 || TWH_CYC < 1 || TWB_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("nand_cmd_seq: cycle parameters must be >= 1");
    end

    nand_state_e     state_q, nxt, after_addr;
    logic            advance, byte_done, we_go, launch_q;
    logic            rb_meta_q, rb_sync_q;
    logic [2:0]      idx_q, nxt_idx, acnt_q;
    logic [39:0]     addr_q;
    logic [7:0]      cmd2_q, nxt_io;
    logic            cmd2_en_q, wait_rb_q;
    logic [TwbW-1:0] twb_cnt_q;

`ifdef NAND_RB_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [ToW-1:0] rb_cnt_q;
    logic           timeout_hit;
`endif

    always_comb begin
        advance    = 1'b0;
        nxt        = state_q;
        nxt_idx    = idx_q;
        after_addr = cmd2_en_q ? StCmd2 : (wait_rb_q ? StTwb : StDone);
`ifdef NAND_RB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            StIdle: if (start) begin
                advance = 1'b1;
                nxt     = StCmd1;
            end
            StCmd1: if (byte_done) begin
                advance = 1'b1;
                nxt     = (acnt_q != 3'd0) ? StAddr : after_addr;
                nxt_idx = 3'd0;
            end
            StAddr: if (byte_done) begin
                advance = 1'b1;
                if (idx_q == acnt_q - 3'd1) begin
                    nxt = after_addr;
                end else begin
                    nxt_idx = idx_q + 3'd1;
                end
            end
            StCmd2: if (byte_done) begin
                advance = 1'b1;
                nxt     = wait_rb_q ? StTwb : StDone;
            end
            StTwb: if (twb_cnt_q == TwbW'(TWB_CYC - 1)) begin
                advance = 1'b1;
                nxt     = StWaitRb;
            end
            StWaitRb: begin
                if (rb_sync_q) begin
                    advance = 1'b1;
                    nxt     = StDone;
                end
`ifdef NAND_RB_TIMEOUT_EN
                else if (rb_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
                    advance     = 1'b1;
                    nxt         = StDone;
                    timeout_hit = 1'b1;
                end
`endif
            end
            StDone: begin
                advance = 1'b1;
                nxt     = StIdle;
            end
            default: begin
                advance = 1'b1;
                nxt     = StIdle;
            end
        endcase
    end

    always_comb begin
        case (nxt)
            StCmd1:  nxt_io = cmd1;
            StAddr:  nxt_io = addr_byte(addr_q, nxt_idx);
            StCmd2:  nxt_io = cmd2_q;
            default: nxt_io = 8'h00;
        endcase
    end

    // First byte gets one setup cycle; later bytes chain straight off byte_done.
    assign we_go = launch_q || (byte_done && (nxt == StAddr || nxt == StCmd2));

    nand_we_timer #(
        .TWP_CYC (TWP_CYC),
        .TWH_CYC (TWH_CYC)
    ) u_we_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (we_go),
        .we_n      (nand_we_n),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rb_meta_q <= 1'b1;
            rb_sync_q <= 1'b1;
        end else begin
            rb_meta_q <= nand_rb_n;
            rb_sync_q <= rb_meta_q;
        end
    end

`ifdef NAND_RB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != StWaitRb) begin
            rb_cnt_q <= '0;
        end else begin
            rb_cnt_q <= rb_cnt_q + ToW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            launch_q    <= 1'b0;
            twb_cnt_q   <= '0;
            addr_q      <= '0;
            acnt_q      <= 3'd0;
            cmd2_en_q   <= 1'b0;
            cmd2_q      <= 8'h00;
            wait_rb_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            nand_ce_n   <= 1'b1;
            nand_cle    <= 1'b0;
            nand_ale    <= 1'b0;
            nand_io_out <= 8'h00;
            nand_io_oe  <= 1'b0;
`ifdef NAND_RB_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else begin
            launch_q  <= advance && (nxt == StCmd1);
            twb_cnt_q <= (state_q == StTwb) ? twb_cnt_q + TwbW'(1) : '0;
            if (state_q == StIdle && start) begin
                addr_q    <= addr;
                acnt_q    <= clamp_addr_cnt(addr_cnt);
                cmd2_en_q <= cmd2_en;
                cmd2_q    <= cmd2;
                wait_rb_q <= wait_rb;
            end
            if (advance) begin
                state_q     <= nxt;
                idx_q       <= nxt_idx;
                busy        <= (nxt != StIdle) && (nxt != StDone);
                done        <= (nxt == StDone);
                nand_ce_n   <= (nxt == StIdle);
                nand_cle    <= (nxt == StCmd1) || (nxt == StCmd2);
                nand_ale    <= (nxt == StAddr);
                nand_io_out <= nxt_io;
                nand_io_oe  <= (nxt == StCmd1) || (nxt == StAddr) || (nxt == StCmd2);
`ifdef NAND_RB_TIMEOUT_EN
                timeout     <= timeout_hit;
`endif
            end
        end
    end

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Scoreboard bench for nand_cmd_seq: expected bytes and done pulses are queued at issue time
// and checked by a negedge monitor on each WE# rise and done pulse.
module tb_nand_cmd_seq;
    import nand_pkg::*;

    localparam int unsigned TWP = 2;
    localparam int unsigned TWH = 2;
    localparam int unsigned TWB = 3;
    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd1 = 8'h00;
    logic [39:0] addr = '0;
    logic [2:0]  addr_cnt = 3'd0;
    logic        cmd2_en = 1'b0;
    logic [7:0]  cmd2 = 8'h00;
    logic        wait_rb = 1'b0;
    logic        nand_rb_n = 1'b1;
    logic        busy, done, timeout;
    logic        nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_io_oe;
    logic [7:0]  nand_io_out;

    nand_cmd_seq #(
        .TWP_CYC     (TWP),
        .TWH_CYC     (TWH),
        .TWB_CYC     (TWB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmd1        (cmd1),
        .addr        (addr),
        .addr_cnt    (addr_cnt),
        .cmd2_en     (cmd2_en),
        .cmd2        (cmd2),
        .wait_rb     (wait_rb),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .nand_ce_n   (nand_ce_n),
        .nand_cle    (nand_cle),
        .nand_ale    (nand_ale),
        .nand_we_n   (nand_we_n),
        .nand_io_out (nand_io_out),
        .nand_io_oe  (nand_io_oe),
        .nand_rb_n   (nand_rb_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit         is_done;
        logic [7:0] io;
        bit         cle;
        bit         ale;
        int         cyc;
        bit         tmo;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void push_byte(input logic [7:0] io, input bit cle, input bit ale);
        exp_t e;
        e.is_done = 1'b0; e.io = io; e.cle = cle; e.ale = ale; e.cyc = 0; e.tmo = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input int c, input bit tmo);
        exp_t e;
        e.is_done = 1'b1; e.io = 8'h00; e.cle = 1'b0; e.ale = 1'b0; e.cyc = c; e.tmo = tmo;
        exp_q.push_back(e);
    endfunction

    // Monitor: a byte is latched by the NAND on each WE# rise while CE# is low.
    bit we_prev = 1'b1;
    int lowc = 0;
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst_n) begin
            we_prev = 1'b1;
            lowc    = 0;
        end else begin
            if (!nand_we_n) lowc++;
            if (nand_we_n && !we_prev && !nand_ce_n) begin
                ok = (exp_q.size() != 0) && !exp_q[0].is_done;
                chk("byte_expected", 64'(ok), 64'd1);
                if (ok) begin
                    e = exp_q.pop_front();
                    chk("byte_io", 64'(nand_io_out), 64'(e.io));
                    chk("byte_cle", 64'(nand_cle), 64'(e.cle));
                    chk("byte_ale", 64'(nand_ale), 64'(e.ale));
                    chk("byte_oe", 64'(nand_io_oe), 64'd1);
                    chk("byte_busy", 64'(busy), 64'd1);
                    chk("byte_twp", 64'(lowc), 64'(TWP));
                end
            end
            if (done) begin
                ok = (exp_q.size() != 0) && exp_q[0].is_done;
                chk("done_expected", 64'(ok), 64'd1);
                if (ok) begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_timeout", 64'(timeout), 64'(e.tmo));
                    chk("done_busy", 64'(busy), 64'd0);
                    chk("done_ce_n", 64'(nand_ce_n), 64'd0);
                end
            end else if (timeout) begin
                chk("timeout_without_done", 64'(timeout), 64'd0);
            end
            if (nand_we_n) lowc = 0;
            we_prev = nand_we_n;
        end
    end

    task automatic issue(input logic [7:0] c1, input logic [39:0] a, input logic [2:0] n,
                         input logic c2e, input logic [7:0] c2, input logic w, output int sc);
        @(posedge clk); #1;
        cmd1 = c1; addr = a; addr_cnt = n; cmd2_en = c2e; cmd2 = c2; wait_rb = w;
        start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk(nm, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;

        // Reset held with start asserted
        start = 1'b1; cmd1 = RESET;
        repeat (4) begin
            @(negedge clk);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_ce_n", 64'(nand_ce_n), 64'd1);
        chk("rst_cle", 64'(nand_cle), 64'd0);
        chk("rst_ale", 64'(nand_ale), 64'd0);
        chk("rst_we_n", 64'(nand_we_n), 64'd1);
        chk("rst_io", 64'(nand_io_out), 64'd0);
        chk("rst_oe", 64'(nand_io_oe), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);

        // RESET command: single CLE byte, done 6 cycles after start
        push_byte(RESET, 1'b1, 1'b0);
        issue(RESET, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0, sc);
        push_done(sc + 6, 1'b0);
        drain(40, "reset_cmd_drain");

        // Page read with R/B# busy for ~100 cycles
        @(posedge clk); #1 nand_rb_n = 1'b0;
        push_byte(READ1, 1'b1, 1'b0);
        push_byte(8'h05, 1'b0, 1'b1);
        push_byte(8'h04, 1'b0, 1'b1);
        push_byte(8'h03, 1'b0, 1'b1);
        push_byte(8'h02, 1'b0, 1'b1);
        push_byte(8'h01, 1'b0, 1'b1);
        push_byte(READ2, 1'b1, 1'b0);
        issue(READ1, 40'h0102030405, 3'd5, 1'b1, READ2, 1'b1, sc);
        while (cyc < sc + 100) begin
            @(posedge clk); #1;
        end
        nand_rb_n = 1'b1;
        push_done(cyc + 3, 1'b0);
        drain(50, "page_read_drain");

        // Busy rejection; addr_cnt=7 clamps to 5 address bytes
        push_byte(READ1, 1'b1, 1'b0);
        push_byte(8'hE5, 1'b0, 1'b1);
        push_byte(8'hD4, 1'b0, 1'b1);
        push_byte(8'hC3, 1'b0, 1'b1);
        push_byte(8'hB2, 1'b0, 1'b1);
        push_byte(8'hA1, 1'b0, 1'b1);
        issue(READ1, 40'hA1B2C3D4E5, 3'd7, 1'b0, 8'h00, 1'b0, sc);
        push_done(sc + 26, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        cmd1 = 8'hAA; addr = 40'hFFFFFFFFFF; addr_cnt = 3'd1; cmd2_en = 1'b1; wait_rb = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drain(60, "reject_drain");
        repeat (20) @(posedge clk);
        chk("reject_single_done", 64'(exp_q.size()), 64'd0);

        // Reset during the third address byte
        push_byte(READ1, 1'b1, 1'b0);
        push_byte(8'h11, 1'b0, 1'b1);
        push_byte(8'h22, 1'b0, 1'b1);
        issue(READ1, 40'h5544332211, 3'd5, 1'b1, READ2, 1'b0, sc);
        while (cyc < sc + 14) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_we_low", 64'(nand_we_n), 64'd0);
        @(negedge clk);
        chk("mid_ce_n", 64'(nand_ce_n), 64'd1);
        chk("mid_we_n", 64'(nand_we_n), 64'd1);
        chk("mid_oe", 64'(nand_io_oe), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_ale", 64'(nand_ale), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        chk("mid_rst_no_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        push_byte(RESET, 1'b1, 1'b0);
        issue(RESET, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0, sc);
        push_done(sc + 6, 1'b0);
        drain(40, "after_rst_drain");

        // Program with R/B# already high on WAIT_RB entry
        push_byte(PROG1, 1'b1, 1'b0);
        push_byte(8'h34, 1'b0, 1'b1);
        push_byte(8'h12, 1'b0, 1'b1);
        push_byte(PROG2, 1'b1, 1'b0);
        issue(PROG1, 40'h0000001234, 3'd2, 1'b1, PROG2, 1'b1, sc);
        push_done(sc + 22, 1'b0);
        drain(60, "rb_high_drain");

`ifdef NAND_RB_TIMEOUT_EN
        // R/B# stuck low: WAIT_RB entered at sc+9, timeout after TMO cycles
        @(posedge clk); #1 nand_rb_n = 1'b0;
        push_byte(RESET, 1'b1, 1'b0);
        issue(RESET, 40'h0, 3'd0, 1'b0, 8'h00, 1'b1, sc);
        push_done(sc + 9 + int'(TMO), 1'b1);
        drain(120, "timeout_drain");
        nand_rb_n = 1'b1;
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
